// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter
// Shares the single-port 320x240 frame-buffer BRAM between three requesters:
//   - display read path (highest priority, held request, combinational grant)
//   - camera write stream (no backpressure, buffered in a small FIFO)
//   - inverse-perspective transform engine (read or write, held request)
// One registered BRAM command is issued per cycle at most. Read data comes
// back two cycles after the grant and is steered by a 2-stage tag pipe.
//
// Ports:
//   clk, reset                      clock, async active-high reset
//   i_cam_we/i_cam_addr/i_cam_data  camera write stream
//   i_rd_req/i_rd_addr, o_rd_gnt    display read request / accept
//   o_rd_valid/o_rd_data            display read return
//   i_tf_req/i_tf_we/i_tf_addr/i_tf_data, o_tf_gnt  transform request / accept
//   o_tf_rvalid/o_tf_rdata          transform read return
//   o_mem_en/o_mem_we/o_mem_addr/o_mem_wdata        registered BRAM command
//   i_mem_rdata                     BRAM read data (one cycle after command)
//   o_overflow                      sticky camera-drop flag
//   o_drop_cnt                      saturating dropped-write counter
//
// Build option: define FB_ARB_DROP_CNT_EN to include the drop counter;
// otherwise o_drop_cnt is tied to zero.

module fb_port_arbiter #(
    parameter int FIFO_DEPTH = 8,
    parameter int HIGH_WATER = 6,
    parameter int DATA_W     = 12,
    parameter int ADDR_W     = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_cam_we,
    input  logic [ADDR_W-1:0] i_cam_addr,
    input  logic [DATA_W-1:0] i_cam_data,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              o_rd_gnt,
    output logic              o_rd_valid,
    output logic [DATA_W-1:0] o_rd_data,
    input  logic              i_tf_req,
    input  logic              i_tf_we,
    input  logic [ADDR_W-1:0] i_tf_addr,
    input  logic [DATA_W-1:0] i_tf_data,
    output logic              o_tf_gnt,
    output logic              o_tf_rvalid,
    output logic [DATA_W-1:0] o_tf_rdata,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_overflow,
    output logic [15:0]       o_drop_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {TAG_NONE, TAG_RD, TAG_TF} tag_t;
    typedef enum logic {RR_CAM, RR_TF} rr_t;

    // Camera FIFO storage and bookkeeping
    logic [ADDR_W+DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [CNT_W-1:0]         fifo_count;
    logic                     fifo_empty;
    logic                     fifo_full;
    logic                     fifo_high;
    logic [ADDR_W+DATA_W-1:0] head_word;
    logic [ADDR_W-1:0]        head_addr;
    logic [DATA_W-1:0]        head_data;
    logic                     push;
    logic                     pop;
    logic                     drop;

    // Grant and round-robin state
    rr_t  rr_q;
    rr_t  rr_d;
    logic rd_gnt;
    logic cam_gnt;
    logic tf_gnt;

    // Return-path tag pipe
    tag_t tag_issue;
    tag_t tag_q1;
    tag_t tag_q2;

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign fifo_high  = (fifo_count >= CNT_W'(HIGH_WATER));
    assign head_word  = fifo_mem[rd_ptr];
    assign head_addr  = head_word[DATA_W +: ADDR_W];
    assign head_data  = head_word[DATA_W-1:0];

    // A full FIFO still accepts a write when its head is popped this cycle.
    assign pop  = cam_gnt;
    assign push = i_cam_we && (!fifo_full || pop);
    assign drop = i_cam_we && fifo_full && !pop;

    // Grant selection: display first, then a nearly full camera FIFO,
    // otherwise alternate between camera and transform.
    always_comb begin
        rd_gnt  = 1'b0;
        cam_gnt = 1'b0;
        tf_gnt  = 1'b0;
        if (i_rd_req) begin
            rd_gnt = 1'b1;
        end else if (fifo_high) begin
            cam_gnt = 1'b1;
        end else if (rr_q == RR_CAM) begin
            if (!fifo_empty)   cam_gnt = 1'b1;
            else if (i_tf_req) tf_gnt  = 1'b1;
        end else begin
            if (i_tf_req)         tf_gnt  = 1'b1;
            else if (!fifo_empty) cam_gnt = 1'b1;
        end
    end

    assign o_rd_gnt = rd_gnt;
    assign o_tf_gnt = tf_gnt;

    // Round-robin pointer points away from whoever was just served;
    // high-water camera grants count as camera service too.
    always_comb begin
        rr_d = rr_q;
        if (cam_gnt)     rr_d = RR_TF;
        else if (tf_gnt) rr_d = RR_CAM;
    end

    // Round-robin pointer register, favouring the camera after reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rr_q <= RR_CAM;
        else       rr_q <= rr_d;
    end

    // FIFO payload array; contents need no reset because the pointers do
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {i_cam_addr, i_cam_data};
    end

    // FIFO pointers and occupancy; power-of-two depth lets pointers wrap freely
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Registered BRAM command; address/data hold over idle cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_mem_en    <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
        end else begin
            o_mem_en <= rd_gnt || cam_gnt || tf_gnt;
            if (rd_gnt) begin
                o_mem_we   <= 1'b0;
                o_mem_addr <= i_rd_addr;
            end else if (cam_gnt) begin
                o_mem_we    <= 1'b1;
                o_mem_addr  <= head_addr;
                o_mem_wdata <= head_data;
            end else if (tf_gnt) begin
                o_mem_we    <= i_tf_we;
                o_mem_addr  <= i_tf_addr;
                o_mem_wdata <= i_tf_data;
            end else begin
                o_mem_we <= 1'b0;
            end
        end
    end

    // Tag for the command being granted now; only reads need a return tag
    always_comb begin
        tag_issue = TAG_NONE;
        if (rd_gnt)                  tag_issue = TAG_RD;
        else if (tf_gnt && !i_tf_we) tag_issue = TAG_TF;
    end

    // Two-stage tag pipe aligns with the BRAM's one-cycle read latency
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_q1 <= TAG_NONE;
            tag_q2 <= TAG_NONE;
        end else begin
            tag_q1 <= tag_issue;
            tag_q2 <= tag_q1;
        end
    end

    assign o_rd_valid  = (tag_q2 == TAG_RD);
    assign o_tf_rvalid = (tag_q2 == TAG_TF);
    assign o_rd_data   = o_rd_valid  ? i_mem_rdata : '0;
    assign o_tf_rdata  = o_tf_rvalid ? i_mem_rdata : '0;

    // Sticky overflow flag, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     o_overflow <= 1'b0;
        else if (drop) o_overflow <= 1'b1;
    end

`ifdef FB_ARB_DROP_CNT_EN
    logic [15:0] drop_cnt_q;

    // Saturating count of dropped camera writes
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                             drop_cnt_q <= '0;
        else if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
    end

    assign o_drop_cnt = drop_cnt_q;
`else
    assign o_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Testbench for fb_port_arbiter: directed vectors with hand-computed
// expectations pushed into scoreboard queues; a negedge monitor pops and
// compares every BRAM command and every read return the DUT presents.

module tb_fb_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_cam_we = 1'b0;
    logic [16:0] i_cam_addr = '0;
    logic [11:0] i_cam_data = '0;
    logic        i_rd_req = 1'b0;
    logic [16:0] i_rd_addr = '0;
    logic        o_rd_gnt;
    logic        o_rd_valid;
    logic [11:0] o_rd_data;
    logic        i_tf_req = 1'b0;
    logic        i_tf_we = 1'b0;
    logic [16:0] i_tf_addr = '0;
    logic [11:0] i_tf_data = '0;
    logic        o_tf_gnt;
    logic        o_tf_rvalid;
    logic [11:0] o_tf_rdata;
    logic        o_mem_en;
    logic        o_mem_we;
    logic [16:0] o_mem_addr;
    logic [11:0] o_mem_wdata;
    logic [11:0] mem_rdata;
    logic        o_overflow;
    logic [15:0] o_drop_cnt;

`ifdef FB_ARB_DROP_CNT_EN
    localparam logic [15:0] EXP_DROPS = 16'd4;
`else
    localparam logic [15:0] EXP_DROPS = 16'd0;
`endif

    typedef struct packed {
        logic        we;
        logic [16:0] addr;
        logic [11:0] data;
    } mem_cmd_t;

    mem_cmd_t    exp_mem[$];
    logic [11:0] exp_rd[$];
    logic [11:0] exp_tf[$];
    int          checks = 0;
    int          failures = 0;
    int          tf_idx;
    mem_cmd_t    mon_cmd;
    logic [11:0] mon_data;

    always #5 clk = ~clk;

    fb_port_arbiter #(
        .FIFO_DEPTH(8),
        .HIGH_WATER(6),
        .DATA_W(12),
        .ADDR_W(17)
    ) dut (
        .clk(clk),
        .reset(reset),
        .i_cam_we(i_cam_we),
        .i_cam_addr(i_cam_addr),
        .i_cam_data(i_cam_data),
        .i_rd_req(i_rd_req),
        .i_rd_addr(i_rd_addr),
        .o_rd_gnt(o_rd_gnt),
        .o_rd_valid(o_rd_valid),
        .o_rd_data(o_rd_data),
        .i_tf_req(i_tf_req),
        .i_tf_we(i_tf_we),
        .i_tf_addr(i_tf_addr),
        .i_tf_data(i_tf_data),
        .o_tf_gnt(o_tf_gnt),
        .o_tf_rvalid(o_tf_rvalid),
        .o_tf_rdata(o_tf_rdata),
        .o_mem_en(o_mem_en),
        .o_mem_we(o_mem_we),
        .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata),
        .i_mem_rdata(mem_rdata),
        .o_overflow(o_overflow),
        .o_drop_cnt(o_drop_cnt)
    );

    // Read-only BRAM contents used by the model
    function automatic logic [11:0] bram_read(input logic [16:0] addr);
        case (addr)
            17'h00005: return 12'h123;
            17'h00202: return 12'h5A5;
            default:   return addr[11:0] ^ 12'hFFF;
        endcase
    endfunction

    // BRAM model: read data appears the cycle after the command
    always @(posedge clk or posedge reset) begin
        if (reset)                     mem_rdata <= '0;
        else if (o_mem_en && !o_mem_we) mem_rdata <= bram_read(o_mem_addr);
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (o_mem_en) begin
                checks++;
                if (exp_mem.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL mem_cmd unexpected: actual we=%0b addr=0x%0h wdata=0x%0h expected none",
                             o_mem_we, o_mem_addr, o_mem_wdata);
                end else begin
                    mon_cmd = exp_mem.pop_front();
                    if (o_mem_we !== mon_cmd.we || o_mem_addr !== mon_cmd.addr ||
                        (mon_cmd.we && o_mem_wdata !== mon_cmd.data)) begin
                        failures++;
                        $display("[TB] FAIL mem_cmd: actual we=%0b addr=0x%0h wdata=0x%0h expected we=%0b addr=0x%0h wdata=0x%0h",
                                 o_mem_we, o_mem_addr, o_mem_wdata, mon_cmd.we, mon_cmd.addr, mon_cmd.data);
                    end
                end
            end
            if (o_rd_valid) begin
                checks++;
                if (exp_rd.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL rd_return unexpected: actual data=0x%0h expected none", o_rd_data);
                end else begin
                    mon_data = exp_rd.pop_front();
                    if (o_rd_data !== mon_data) begin
                        failures++;
                        $display("[TB] FAIL rd_return: actual=0x%0h expected=0x%0h", o_rd_data, mon_data);
                    end
                end
            end
            if (o_tf_rvalid) begin
                checks++;
                if (exp_tf.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL tf_return unexpected: actual data=0x%0h expected none", o_tf_rdata);
                end else begin
                    mon_data = exp_tf.pop_front();
                    if (o_tf_rdata !== mon_data) begin
                        failures++;
                        $display("[TB] FAIL tf_return: actual=0x%0h expected=0x%0h", o_tf_rdata, mon_data);
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic pushMem(input logic we, input logic [16:0] addr, input logic [11:0] data);
        mem_cmd_t c;
        c.we   = we;
        c.addr = addr;
        c.data = data;
        exp_mem.push_back(c);
    endtask

    task automatic applyStimulus(input logic rd_req, input logic [16:0] rd_addr,
                                 input logic cam_we, input logic [16:0] cam_addr, input logic [11:0] cam_data,
                                 input logic tf_req, input logic tf_we, input logic [16:0] tf_addr,
                                 input logic [11:0] tf_data);
        @(posedge clk);
        #1;
        i_rd_req   = rd_req;
        i_rd_addr  = rd_addr;
        i_cam_we   = cam_we;
        i_cam_addr = cam_addr;
        i_cam_data = cam_data;
        i_tf_req   = tf_req;
        i_tf_we    = tf_we;
        i_tf_addr  = tf_addr;
        i_tf_data  = tf_data;
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++)
            applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_mem_en"},    32'(o_mem_en),    32'd0);
        checkOutput({tag, "_mem_we"},    32'(o_mem_we),    32'd0);
        checkOutput({tag, "_mem_addr"},  32'(o_mem_addr),  32'd0);
        checkOutput({tag, "_mem_wdata"}, 32'(o_mem_wdata), 32'd0);
        checkOutput({tag, "_rd_valid"},  32'(o_rd_valid),  32'd0);
        checkOutput({tag, "_tf_rvalid"}, 32'(o_tf_rvalid), 32'd0);
        checkOutput({tag, "_overflow"},  32'(o_overflow),  32'd0);
        checkOutput({tag, "_drop_cnt"},  32'(o_drop_cnt),  32'd0);
    endtask

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkResetValues("reset");
        @(posedge clk);
        #1 reset = 1'b0;

        // Single camera write into an idle arbiter: command two cycles later
        pushMem(1'b1, 17'h00141, 12'hABC);
        applyStimulus(1'b0, '0, 1'b1, 17'h00141, 12'hABC, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        checkOutput("t1_mem_en_c0", 32'(o_mem_en), 32'd0);
        idleCycles(1);
        @(negedge clk);
        checkOutput("t1_mem_en_c1", 32'(o_mem_en), 32'd0);
        checkOutput("t1_rd_gnt", 32'(o_rd_gnt), 32'd0);
        checkOutput("t1_tf_gnt", 32'(o_tf_gnt), 32'd0);
        idleCycles(1);
        @(negedge clk);
        checkOutput("t1_mem_en_c2", 32'(o_mem_en), 32'd1);
        checkOutput("t1_mem_we_c2", 32'(o_mem_we), 32'd1);
        idleCycles(2);
        @(negedge clk);
        checkOutput("t1_overflow", 32'(o_overflow), 32'd0);

        // Display read of address 5, returns 0x123 two cycles after grant
        pushMem(1'b0, 17'h00005, 12'h000);
        exp_rd.push_back(12'h123);
        applyStimulus(1'b1, 17'h00005, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        checkOutput("t2_rd_gnt", 32'(o_rd_gnt), 32'd1);
        checkOutput("t2_tf_gnt", 32'(o_tf_gnt), 32'd0);
        idleCycles(1);
        @(negedge clk);
        checkOutput("t2_rd_valid_c1", 32'(o_rd_valid), 32'd0);
        idleCycles(1);
        @(negedge clk);
        checkOutput("t2_rd_valid_c2", 32'(o_rd_valid), 32'd1);
        checkOutput("t2_rd_data_c2", 32'(o_rd_data), 32'h123);
        checkOutput("t2_tf_rvalid_c2", 32'(o_tf_rvalid), 32'd0);
        idleCycles(1);
        @(negedge clk);
        checkOutput("t2_rd_data_c3", 32'(o_rd_data), 32'd0);

        // Continuous transform plus camera every 2nd cycle: strict alternation
        // starting with the transform (pointer moved away from the camera).
        for (int k = 0; k < 4; k++) begin
            pushMem(k != 2, 17'(32'h200 + k), 12'(32'h100 + k));
            pushMem(1'b1, 17'(32'h300 + k), 12'(32'hC00 + k));
        end
        exp_tf.push_back(12'h5A5);
        tf_idx = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, '0, (i % 2 == 0), 17'(32'h300 + i / 2), 12'(32'hC00 + i / 2),
                          tf_idx < 4, tf_idx != 2, 17'(32'h200 + tf_idx), 12'(32'h100 + tf_idx));
            @(negedge clk);
            if (o_tf_gnt) tf_idx++;
        end
        idleCycles(4);
        @(negedge clk);
        checkOutput("t3_tf_grants", 32'(tf_idx), 32'd4);
        checkOutput("t3_overflow", 32'(o_overflow), 32'd0);
        checkOutput("t3_drop_cnt", 32'(o_drop_cnt), 32'd0);

        // Display holds the port 12 cycles while the camera writes every cycle
        for (int i = 0; i < 12; i++) begin
            pushMem(1'b0, 17'h00005, 12'h000);
            exp_rd.push_back(12'h123);
        end
        for (int k = 0; k < 8; k++)
            pushMem(1'b1, 17'(32'h400 + k), 12'(32'hD00 + k));
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 17'h00005, 1'b1, 17'(32'h400 + i), 12'(32'hD00 + i), 1'b0, 1'b0, '0, '0);
            @(negedge clk);
            if (i == 8) checkOutput("t4_overflow_before_drop", 32'(o_overflow), 32'd0);
            if (i == 9) checkOutput("t4_overflow_after_drop", 32'(o_overflow), 32'd1);
        end
        idleCycles(1);
        @(negedge clk);
        checkOutput("t4_overflow", 32'(o_overflow), 32'd1);
        checkOutput("t4_drop_cnt", 32'(o_drop_cnt), 32'(EXP_DROPS));
        idleCycles(10);

        // FIFO at 6 with transform waiting: camera first, then alternation
        for (int i = 0; i < 6; i++) begin
            pushMem(1'b0, 17'h00005, 12'h000);
            exp_rd.push_back(12'h123);
        end
        for (int k = 0; k < 3; k++) begin
            pushMem(1'b1, 17'(32'h600 + k), 12'(32'hE00 + k));
            pushMem(1'b1, 17'(32'h500 + k), 12'(32'h200 + k));
        end
        for (int k = 3; k < 6; k++)
            pushMem(1'b1, 17'(32'h600 + k), 12'(32'hE00 + k));
        tf_idx = 0;
        for (int i = 0; i < 15; i++) begin
            applyStimulus(i < 6, 17'h00005, i < 6, 17'(32'h600 + i), 12'(32'hE00 + i),
                          (i >= 6) && (tf_idx < 3), 1'b1, 17'(32'h500 + tf_idx), 12'(32'h200 + tf_idx));
            @(negedge clk);
            if (i == 6) checkOutput("t5_hw_cam_wins", 32'(o_tf_gnt), 32'd0);
            if (i == 7) checkOutput("t5_rr_resumes", 32'(o_tf_gnt), 32'd1);
            if (o_tf_gnt) tf_idx++;
        end
        idleCycles(4);
        @(negedge clk);
        checkOutput("t5_drop_cnt", 32'(o_drop_cnt), 32'(EXP_DROPS));

        // Reset one cycle after a display grant, with a camera entry queued
        applyStimulus(1'b1, 17'h00005, 1'b1, 17'h00700, 12'hF00, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        checkOutput("t6_rd_gnt", 32'(o_rd_gnt), 32'd1);
        @(posedge clk);
        #1;
        reset     = 1'b1;
        i_rd_req  = 1'b0;
        i_cam_we  = 1'b0;
        @(negedge clk);
        checkResetValues("t6_in_reset");
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idleCycles(1);
            @(negedge clk);
            checkOutput("t6_no_rd_valid", 32'(o_rd_valid), 32'd0);
            checkOutput("t6_no_mem_en", 32'(o_mem_en), 32'd0);
        end
        checkOutput("t6_overflow", 32'(o_overflow), 32'd0);

        // After reset the pointer favours the camera over a waiting transform
        pushMem(1'b1, 17'h00080, 12'h0AA);
        pushMem(1'b1, 17'h00090, 12'h0BB);
        applyStimulus(1'b0, '0, 1'b1, 17'h00080, 12'h0AA, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b1, 17'h00090, 12'h0BB);
        @(negedge clk);
        checkOutput("t7_cam_first", 32'(o_tf_gnt), 32'd0);
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b1, 17'h00090, 12'h0BB);
        @(negedge clk);
        checkOutput("t7_tf_second", 32'(o_tf_gnt), 32'd1);
        idleCycles(6);
        @(negedge clk);

        checkOutput("left_mem_cmds", 32'(exp_mem.size()), 32'd0);
        checkOutput("left_rd_returns", 32'(exp_rd.size()), 32'd0);
        checkOutput("left_tf_returns", 32'(exp_tf.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fb_port_arbiter.md
# fb_port_arbiter

Arbiter for the single-port 320×240 frame-buffer BRAM (17-bit address, 12-bit RGB444 words). It shares the memory between three requesters: the display read path, the camera write stream from the address generator, and the inverse-perspective transform engine (read/write). It buffers the camera stream in a small FIFO because that stream has no backpressure. It issues at most one registered memory command per cycle.

## Interface
- FIFO_DEPTH, 8: camera write FIFO entries (power of two, ≥4)
- HIGH_WATER, 6: FIFO occupancy at which the camera outranks the transform engine
- DATA_W, 12: pixel word width
- ADDR_W, 17: frame-buffer address width
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high
- i_cam_we / i_cam_addr / i_cam_data  in  1/ADDR_W/DATA_W  camera write stream (address-generator output), no backpressure
- i_rd_req / i_rd_addr  in  1/ADDR_W  display read request, held until granted
- o_rd_gnt  out  1  display request accepted this cycle (combinational)
- o_rd_valid / o_rd_data  out  1/DATA_W  display read return
- i_tf_req / i_tf_we / i_tf_addr / i_tf_data  in  1/1/ADDR_W/DATA_W  transform request, held until granted
- o_tf_gnt  out  1  transform request accepted this cycle (combinational)
- o_tf_rvalid / o_tf_rdata  out  1/DATA_W  transform read return
- o_mem_en / o_mem_we / o_mem_addr / o_mem_wdata  out  1/1/ADDR_W/DATA_W  registered BRAM command
- i_mem_rdata  in  DATA_W  BRAM read data, one cycle after command
- o_overflow  out  1  sticky: a camera write was dropped
- o_drop_cnt  out  16  dropped camera writes (see Configuration)

## Operation
- Camera FIFO push occurs when i_cam_we=1 and the FIFO is not full. A pop of the granted entry and a push in the same cycle are both allowed when the FIFO is full.
- If the FIFO is full with no pop that cycle, the write is dropped and o_overflow is set. o_overflow clears only on reset.
- Grant decision each cycle, fixed order:
  1. i_rd_req → display.
  2. FIFO occupancy ≥ HIGH_WATER → camera.
  3. Otherwise round-robin between camera (FIFO non-empty) and transform (i_tf_req). The pointer moves to the other requester after each grant to either one. After reset the pointer favours the camera.
- Exactly one grant per cycle at most. An idle cycle gives o_mem_en=0.
- A transform write grant gives a BRAM write. A transform read grant gives a BRAM read with return tag TF.
- Camera grants are always writes. Display grants are always reads with return tag RD.
- Return path: a 2-stage tag shift register (none/RD/TF) steers i_mem_rdata to o_rd_data or o_tf_rdata. o_rd_data and o_tf_rdata pass i_mem_rdata combinationally while their valid is high and hold 0 otherwise.
- Address/data are not range-checked; the address generator guarantees bounds.

## Timing
- Grant cycle T: o_*_gnt high combinationally, or the FIFO pops.
- T+1: o_mem_* registered.
- T+2: i_mem_rdata valid, and o_rd_valid or o_tf_rvalid high.
- Read latency is 2 cycles; full throughput is one command per cycle.
- Camera write minimum latency is input cycle → FIFO → grant next cycle → o_mem_* one cycle later, which is 2 cycles when the FIFO is empty and uncontested.
- Reset values: o_mem_en=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_rd_valid=0, o_tf_rvalid=0, o_overflow=0, o_drop_cnt=0. FIFO empty, tags cleared.
- Reset asserted mid-operation: in-flight reads produce no valid and queued camera writes are discarded.
- Display saturating the port starves the others. The FIFO then fills and drops, and this is reported via o_overflow.

## Configuration
- FB_ARB_DROP_CNT_EN defined:
  - o_drop_cnt counts every dropped camera write and saturates at 16'hFFFF.
  - The count clears on reset only.
- Macro undefined:
  - o_drop_cnt is tied to 0 and no counter is synthesised.
  - o_overflow behaves identically in both builds.

## Test plan
- Idle, one camera write addr=0x00141 data=0xABC → o_mem_en=1, we=1, addr=0x00141, wdata=0xABC two cycles later. No other outputs toggle.
- Display read addr=5 with a BRAM model returning 0x123 → o_rd_gnt in the same cycle; o_rd_valid=1 with o_rd_data=0x123 exactly 2 cycles after grant; o_tf_rvalid stays 0.
- Continuous transform requests plus a camera write every 2nd cycle with FIFO below HIGH_WATER → grants alternate camera/transform, and no drops occur.
- i_rd_req held for 12 cycles while the camera writes every cycle → FIFO fills at 8 and the 9th write drops. o_overflow=1, o_drop_cnt=4 after 12 cycles with the macro (0 without). Entries 1–8 are written in order after release.
- FIFO at 6 entries with i_tf_req high → camera is granted until occupancy is 5, then round-robin resumes.
- Reset pulsed one cycle after a display-read grant → no o_rd_valid, all outputs return to reset values, FIFO empty, o_overflow=0.
